trigger_sequencer: RTL

- Multi-channel trigger scheduler that sequences a bank of delayed-pulse channels from one external trigger.
- On an accepted trigger edge, each channel emits one pulse with its own programmable delay and width.
- Arm/disarm control, post-sequence holdoff and a missed-trigger counter included.
- Sits between the front-panel trigger input and the downstream gate/strobe consumers; configured by the control register bus.

---
 rtl/trigger_sequencer_if.sv | 17 +
 rtl/trigger_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer_if.sv
// Configuration write channel for trigger_sequencer: valid/ready handshake
// carrying a channel index, register select and data word.
interface trigger_sequencer_if #(
  parameter int NUM_CH        = 4,
  parameter int counter_width = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [CH_W-1:0]          cfg_ch;
  logic                     cfg_sel;
  logic [counter_width-1:0] cfg_data;

  modport master (output cfg_valid, cfg_ch, cfg_sel, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_sel, cfg_data, output cfg_ready);
endinterface

// File: rtl/trigger_sequencer.sv
// Multi-channel trigger sequencer: one accepted trigger edge launches a
// delayed pulse on every channel with a non-zero width.
//
// state   | meaning
// IDLE    | disarmed, configuration writes accepted, tmax tracked
// ARMED   | waiting for a synchronized trigger edge
// RUNNING | time counter t advancing, channel pulses generated
// HOLDOFF | post-sequence dead time, h counts 0..holdoff
module trigger_sequencer #(
  parameter int NUM_CH        = 4,
  parameter int counter_width = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     trigger_in,
  input  logic                     arm,
  input  logic                     disarm,
  input  logic                     auto_rearm,
  input  logic [counter_width-1:0] holdoff,
  trigger_sequencer_if.slave       cfg,
  output logic [NUM_CH-1:0]        channel_out,
  output logic                     armed,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              missed_cnt
);
  localparam int CW1  = counter_width + 1;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, RUNNING, HOLDOFF} state_t;

  state_t                   state, state_nx;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     trig_prev;
  logic                     trig_edge;
  logic [counter_width-1:0] delay_q [NUM_CH];
  logic [counter_width-1:0] width_q [NUM_CH];
  logic [CW1-1:0]           end_t   [NUM_CH];
  logic [CW1-1:0]           t;
  logic [counter_width-1:0] h;
  logic [CW1-1:0]           tmax, tmax_nx;
  logic [NUM_CH-1:0]        ch_hit;
  logic                     t_clr, t_inc, h_clr, h_inc;

  assign trig_edge     = sync_q[SYNC_STAGES-1] & ~trig_prev;
  assign armed         = (state == ARMED);
  assign busy          = (state == RUNNING) || (state == HOLDOFF);
  assign cfg.cfg_ready = (state == IDLE);

  // Synchronize the asynchronous trigger and keep the previous level for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      trig_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], trigger_in};
      trig_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Per-channel delay/width registers, writable only while IDLE; unknown channels are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        delay_q[i] <= '0;
        width_q[i] <= '0;
      end
    end else if (cfg.cfg_valid && cfg.cfg_ready) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg.cfg_ch == CH_W'(i)) begin
          if (cfg.cfg_sel) width_q[i] <= cfg.cfg_data;
          else             delay_q[i] <= cfg.cfg_data;
        end
      end
    end
  end

  // Pulse end times, the sequence length and per-channel window compares, all one bit wider.
  always_comb begin
    tmax_nx = '0;
    ch_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      end_t[i]  = {1'b0, delay_q[i]} + {1'b0, width_q[i]};
      ch_hit[i] = (t >= {1'b0, delay_q[i]}) && (t < end_t[i]);
      if ((width_q[i] != '0) && (end_t[i] > tmax_nx)) tmax_nx = end_t[i];
    end
  end

  // Sequence length is frozen outside IDLE so it cannot move under a running sequence.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           tmax <= '0;
    else if (state == IDLE) tmax <= tmax_nx;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state, counter controls and the done strobe; disarm overrides everything else.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    t_clr    = 1'b0;
    t_inc    = 1'b0;
    h_clr    = 1'b0;
    h_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (arm && !disarm) state_nx = ARMED;
      end
      ARMED: begin
        if (disarm) state_nx = IDLE;
        else if (trig_edge) begin
          state_nx = RUNNING;
          t_clr    = 1'b1;
        end
      end
      RUNNING: begin
        if (disarm) state_nx = IDLE;
        else if (t == tmax) begin
          state_nx = HOLDOFF;
          done     = 1'b1;
          h_clr    = 1'b1;
        end else t_inc = 1'b1;
      end
      HOLDOFF: begin
        if (disarm) state_nx = IDLE;
        else if (h == holdoff) state_nx = auto_rearm ? ARMED : IDLE;
        else h_inc = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequence time and holdoff counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t <= '0;
      h <= '0;
    end else begin
      if (t_clr)      t <= '0;
      else if (t_inc) t <= t + 1'b1;
      if (h_clr)      h <= '0;
      else if (h_inc) h <= h + 1'b1;
    end
  end

  // Registered channel pulses; an abort forces them low on the following cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           channel_out <= '0;
    else if ((state == RUNNING) && !disarm) channel_out <= ch_hit;
    else                                    channel_out <= '0;
  end

  // Count trigger edges that arrive while a sequence or its holdoff is in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) missed_cnt <= '0;
    else if (trig_edge && busy && (missed_cnt != 16'hFFFF)) missed_cnt <= missed_cnt + 16'd1;
  end
endmodule
